// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with configurable width/depth, threshold flags,
// sticky overflow/underflow flags and a selectable read mode.
//
// Ports:
//   clk          - clock; all state changes on rising edge
//   initb        - asynchronous active-low reset
//   data_in      - write data
//   write_en     - push request (dropped and flagged when full)
//   read_en      - pop request (ignored and flagged when empty)
//   clr_err      - clears overflow/underflow at a rising edge
//   data_out     - read data (registered or first-word-fall-through)
//   full, empty  - occupancy flags
//   almost_full  - count >= AF_LEVEL
//   almost_empty - count <= AE_LEVEL
//   count        - current occupancy, 0..DEPTH
//   overflow     - sticky: write attempted while full
//   underflow    - sticky: read attempted while empty
module param_sync_fifo #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned AF_LEVEL = DEPTH - 2,
   parameter int unsigned AE_LEVEL = 2,
   parameter int unsigned FWFT     = 0
) (
   input  logic                   clk,
   input  logic                   initb,
   input  logic [DATA_W-1:0]      data_in,
   input  logic                   write_en,
   input  logic                   read_en,
   input  logic                   clr_err,
   output logic [DATA_W-1:0]      data_out,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   localparam logic [CW-1:0] FullLvl = CW'(DEPTH);
   localparam logic [CW-1:0] AfLvl   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AeLvl   = CW'(AE_LEVEL);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [CW-1:0]     r_count;
   logic [CW-1:0]     w_count_d;
   logic              r_ovf;
   logic              r_udf;
   logic              w_ovf_d;
   logic              w_udf_d;
   logic              w_wr_acc;
   logic              w_rd_acc;

   // Flags decode straight from the registered count.
   assign full         = (r_count == FullLvl);
   assign empty        = (r_count == '0);
   assign almost_full  = (r_count >= AfLvl);
   assign almost_empty = (r_count <= AeLvl);
   assign count        = r_count;
   assign overflow     = r_ovf;
   assign underflow    = r_udf;

   // A write at full is dropped even if a read frees a slot in the same cycle.
   assign w_wr_acc = write_en & ~full;
   assign w_rd_acc = read_en & ~empty;

   always_comb begin
      w_count_d = r_count;
      unique case ({w_wr_acc, w_rd_acc})
         2'b10:   w_count_d = r_count + CW'(1);
         2'b01:   w_count_d = r_count - CW'(1);
         default: w_count_d = r_count;
      endcase
   end

   // New errors take priority over a concurrent clear.
   always_comb begin
      w_ovf_d = r_ovf;
      w_udf_d = r_udf;
      if (clr_err) begin
         w_ovf_d = 1'b0;
         w_udf_d = 1'b0;
      end
      if (write_en && full) w_ovf_d = 1'b1;
      if (read_en && empty) w_udf_d = 1'b1;
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_wr_acc) r_mem[r_wptr] <= data_in;
   end

   always_ff @(posedge clk or negedge initb) begin
      if (!initb) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else begin
         if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
         if (w_rd_acc) r_rptr <= r_rptr + AW'(1);
         r_count <= w_count_d;
         r_ovf   <= w_ovf_d;
         r_udf   <= w_udf_d;
      end
   end

   if (FWFT != 0) begin : g_fwft
      // Head entry presented combinationally; forced to zero while empty so reset reads 0.
      assign data_out = empty ? '0 : r_mem[r_rptr];
   end else begin : g_reg
      logic [DATA_W-1:0] r_dout;

      always_ff @(posedge clk or negedge initb) begin
         if (!initb) begin
            r_dout <= '0;
         end else if (w_rd_acc) begin
            r_dout <= r_mem[r_rptr];
         end
      end

      assign data_out = r_dout;
   end

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: scoreboard bench for param_sync_fifo. A registered-read instance and a
// first-word-fall-through instance share all stimulus.
module tb_param_sync_fifo;

   localparam int DW = 8;
   localparam int DP = 16;

   logic          clk = 1'b0;
   logic          initb = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic          write_en = 1'b0;
   logic          read_en = 1'b0;
   logic          clr_err = 1'b0;

   logic [DW-1:0] data_out, data_out_f;
   logic          full, empty, almost_full, almost_empty, overflow, underflow;
   logic          full_f, empty_f, almost_full_f, almost_empty_f, overflow_f, underflow_f;
   logic [4:0]    count, count_f;

   int total = 0;
   int bad = 0;

   // Scoreboard / model state
   logic [DW-1:0] sb[$];
   logic [DW-1:0] exp_rd;
   bit            rd_valid;
   bit            m_ovf, m_udf;
   logic [DW-1:0] m_dout;

   always #5 clk = ~clk;

   param_sync_fifo #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_dut (
      .clk(clk), .initb(initb), .data_in(data_in), .write_en(write_en), .read_en(read_en),
      .clr_err(clr_err), .data_out(data_out), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   param_sync_fifo #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
      .clk(clk), .initb(initb), .data_in(data_in), .write_en(write_en), .read_en(read_en),
      .clr_err(clr_err), .data_out(data_out_f), .full(full_f), .empty(empty_f),
      .almost_full(almost_full_f), .almost_empty(almost_empty_f), .count(count_f),
      .overflow(overflow_f), .underflow(underflow_f)
   );

   // Drive one cycle of stimulus, advance past the edge, and update the model.
   task automatic drive(input logic we, input logic re, input logic [DW-1:0] din,
                        input logic clr);
      bit m_full, m_empty, wacc, racc;
      m_full  = (sb.size() == DP);
      m_empty = (sb.size() == 0);
      wacc = we && !m_full;
      racc = re && !m_empty;
      write_en = we;
      read_en  = re;
      data_in  = din;
      clr_err  = clr;
      @(posedge clk);
      #1;
      write_en = 1'b0;
      read_en  = 1'b0;
      clr_err  = 1'b0;
      rd_valid = racc;
      if (racc) begin
         exp_rd = sb.pop_front();
         m_dout = exp_rd;
      end
      if (wacc) sb.push_back(din);
      if (clr) begin
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end
      if (we && m_full) m_ovf = 1'b1;
      if (re && m_empty) m_udf = 1'b1;
   endtask

   task automatic model_clear();
      sb.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_dout = '0;
      rd_valid = 1'b0;
   endtask

   task automatic test_reset();
      model_clear();
      initb = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      total++;
      if ({count, empty, almost_empty, full, almost_full, overflow, underflow} !==
          {5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset_flags: got cnt=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b, want 0 1 1 0 0 0 0",
                  count, empty, almost_empty, full, almost_full, overflow, underflow);
      end
      total++;
      if (data_out !== 8'h00) begin
         bad++;
         $display("FAIL reset_dout: got %h want 00", data_out);
      end
      initb = 1'b1;
   endtask

   task automatic test_fill_overflow();
      for (int i = 1; i <= 16; i++) begin
         drive(1'b1, 1'b0, 8'(i), 1'b0);
         total++;
         if (count !== 5'(sb.size())) begin
            bad++;
            $display("FAIL fill_count: got %0d want %0d", count, sb.size());
         end
         if (i == 1) begin
            total++;
            if (data_out_f !== 8'h01) begin
               bad++;
               $display("FAIL fwft_first: got %h want 01", data_out_f);
            end
         end
      end
      total++;
      if (full !== 1'b1 || overflow !== 1'b0) begin
         bad++;
         $display("FAIL full_16: got full=%b ovf=%b want 1 0", full, overflow);
      end
      drive(1'b1, 1'b0, 8'hAA, 1'b0);
      total++;
      if (overflow !== m_ovf || count !== 5'd16 || full !== 1'b1) begin
         bad++;
         $display("FAIL overflow: got ovf=%b cnt=%0d full=%b want %b 16 1",
                  overflow, count, full, m_ovf);
      end
      for (int i = 0; i < 16; i++) begin
         total++;
         if (data_out_f !== sb[0]) begin
            bad++;
            $display("FAIL fwft_head: got %h want %h", data_out_f, sb[0]);
         end
         drive(1'b0, 1'b1, 8'h00, 1'b0);
         total++;
         if (data_out !== exp_rd) begin
            bad++;
            $display("FAIL drain_data: got %h want %h", data_out, exp_rd);
         end
      end
      total++;
      if (empty !== 1'b1 || count !== 5'd0) begin
         bad++;
         $display("FAIL drain_empty: got empty=%b cnt=%0d want 1 0", empty, count);
      end
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      total++;
      if (overflow !== m_ovf) begin
         bad++;
         $display("FAIL ovf_clear: got %b want %b", overflow, m_ovf);
      end
   endtask

   task automatic test_underflow();
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      total++;
      if (underflow !== m_udf || data_out !== m_dout || count !== 5'd0) begin
         bad++;
         $display("FAIL underflow: got udf=%b dout=%h cnt=%0d want %b %h 0",
                  underflow, data_out, count, m_udf, m_dout);
      end
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      total++;
      if (underflow !== m_udf) begin
         bad++;
         $display("FAIL udf_clear: got %b want %b", underflow, m_udf);
      end
      drive(1'b0, 1'b1, 8'h00, 1'b1);
      total++;
      if (underflow !== m_udf) begin
         bad++;
         $display("FAIL udf_clr_race: got %b want %b", underflow, m_udf);
      end
      drive(1'b0, 1'b0, 8'h00, 1'b1);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b1, 8'(8'h50 + i), 1'b0);
         total++;
         if (count !== 5'd8 || data_out !== exp_rd || !rd_valid) begin
            bad++;
            $display("FAIL b2b: got cnt=%0d dout=%h want 8 %h", count, data_out, exp_rd);
         end
      end
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, 8'h00, 1'b0);
         total++;
         if (data_out !== exp_rd) begin
            bad++;
            $display("FAIL b2b_drain: got %h want %h", data_out, exp_rd);
         end
      end
   endtask

   task automatic test_thresholds();
      for (int i = 1; i <= 16; i++) begin
         drive(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
         total++;
         if (almost_empty !== (i <= 2) || almost_full !== (i >= 14) || full !== (i == 16)
             || empty !== 1'b0) begin
            bad++;
            $display("FAIL thr_fill: cnt=%0d got ae=%b af=%b f=%b e=%b", i, almost_empty,
                     almost_full, full, empty);
         end
      end
      for (int i = 15; i >= 0; i--) begin
         drive(1'b0, 1'b1, 8'h00, 1'b0);
         total++;
         if (almost_empty !== (i <= 2) || almost_full !== (i >= 14) || full !== 1'b0
             || empty !== (i == 0) || data_out !== exp_rd) begin
            bad++;
            $display("FAIL thr_drain: cnt=%0d got ae=%b af=%b e=%b dout=%h want dout=%h", i,
                     almost_empty, almost_full, empty, data_out, exp_rd);
         end
      end
   endtask

   task automatic test_async_reset();
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'(8'hE1 + i), 1'b0);
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      #3;
      initb = 1'b0;
      #1;
      model_clear();
      total++;
      if ({count, empty, almost_empty, full, almost_full, overflow, underflow} !==
          {5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0} || data_out !== 8'h00) begin
         bad++;
         $display("FAIL async_reset: got cnt=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b dout=%h",
                  count, empty, almost_empty, full, almost_full, overflow, underflow, data_out);
      end
      @(posedge clk);
      #2;
      initb = 1'b1;
      drive(1'b1, 1'b0, 8'h77, 1'b0);
      total++;
      if (count !== 5'd1 || empty !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_write: got cnt=%0d e=%b want 1 0", count, empty);
      end
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      total++;
      if (data_out !== exp_rd || count !== 5'd0) begin
         bad++;
         $display("FAIL post_reset_read: got %h cnt=%0d want %h 0", data_out, count, exp_rd);
      end
   endtask

   initial begin
      test_reset();
      test_fill_overflow();
      test_underflow();
      test_back_to_back();
      test_thresholds();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
Parameters:
REQ-001 DATA_W, 8, data width in bits (>=1).
REQ-002 DEPTH, 16, number of entries; power of two, >=4.
REQ-003 AF_LEVEL, DEPTH-2, almost_full threshold (1..DEPTH).
REQ-004 AE_LEVEL, 2, almost_empty threshold (0..DEPTH-1).
REQ-005 FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.

Ports:
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 initb  input  1  reset; asynchronous, active-low.
REQ-008 data_in  input  DATA_W  write data.
REQ-009 write_en  input  1  push request.
REQ-010 read_en  input  1  pop request.
REQ-011 clr_err  input  1  clears sticky error flags.
REQ-012 data_out  output  DATA_W  read data.
REQ-013 full / empty  output  1 each  occupancy flags.
REQ-014 almost_full / almost_empty  output  1 each  threshold flags.
REQ-015 count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 overflow / underflow  output  1 each  sticky error flags.

Function
REQ-017 Storage SHALL be a DEPTH x DATA_W array with write and read pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-018 Write accepted iff write_en=1 and full=0: data_in stored at write pointer, pointer increments, at the same edge.
REQ-019 Read accepted iff read_en=1 and empty=0: read pointer increments at that edge.
REQ-020 count SHALL be +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
REQ-021 Simultaneous accepted read and write SHALL both complete in the same cycle with FIFO order preserved.
REQ-022 Write at full SHALL be accepted only as specified in REQ-018 (no pass-through even with concurrent read).
REQ-023 full = (count==DEPTH); empty = (count==0); almost_full = (count>=AF_LEVEL); almost_empty = (count<=AE_LEVEL); all decoded from registered count, no added latency.
REQ-024 FWFT=0: on accepted read, data_out SHALL show the head entry one cycle after the read edge; otherwise data_out holds its value.
REQ-025 FWFT=1: data_out SHALL continuously present the head entry while empty=0; value when empty=1 is don't-care; accepted read advances to the next entry the following cycle.
REQ-026 write_en=1 with full=1 SHALL drop the data, leave pointers/count unchanged, and set overflow at that edge.
REQ-027 read_en=1 with empty=1 SHALL leave pointers/count/data_out unchanged and set underflow at that edge.
REQ-028 overflow/underflow SHALL stay set until clr_err=1 clears them at a rising edge; a new error in the same cycle as clr_err SHALL win (flag remains 1).

Reset
REQ-029 initb=0 SHALL immediately, independent of clk: pointers=0, count=0, data_out=0, overflow=0, underflow=0; hence empty=1, almost_empty=1, full=0, almost_full=0.
REQ-030 Reset mid-operation SHALL discard all contents; storage array is not cleared and not required to be.
REQ-031 Requests at the first rising edge after initb deasserts SHALL be processed normally.

Verification (DEPTH=16, DATA_W=8, AF_LEVEL=14, AE_LEVEL=2)
REQ-032 Assert initb=0 mid-clock -> outputs take REQ-029 values before next edge; count=0, empty=1.
REQ-033 Write 0x01..0x10, then write 0xAA -> full=1 after 16th, overflow=1 after 17th; read 16 -> 0x01..0x10 in order, 0xAA never appears; empty=1 at end.
REQ-034 Read with FIFO empty -> underflow=1, data_out unchanged; clr_err pulse -> underflow=0; clr_err with concurrent empty read -> underflow stays 1.
REQ-035 Fill to 8, then 20 cycles of simultaneous write/read -> count stays 8, read data equals write data in order across pointer wrap.
REQ-036 Fill one at a time -> almost_empty deasserts at count 3, almost_full asserts at count 14; drain reverses at same counts.
REQ-037 Repeat REQ-033 with FWFT=1 -> data_out=0x01 one cycle after first write, with no read issued.
